sp_ram_arbiter: RTL and testbench
=================================

// Module: sp_ram_arbiter
// PURPOSE
//  Two-master round-robin arbiter sitting directly upstream of the single-port RAM wrapper.
//  Accepts req/gnt/rvalid transactions from two masters (port0 = core data side,
//  port1 = AXI/debug bridge side) and drives one RAM access per cycle.
//  Routes the 1-cycle-latency RAM read data back to the granted master.
//  Holds each port's last read data stable between responses.
// PARAMETERS
//  ADDR_WIDTH  15   byte address width, passed unchanged to the RAM wrapper
//  DATA_WIDTH  32   data width; must be a multiple of 8
//  BE_WIDTH    DATA_WIDTH/8   byte-enable width (derived, do not override)
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rstn_i         in   1           asynchronous active-low reset
//  pN_req_i       in   1           N=0,1: request valid
//  pN_gnt_o       out  1           request accepted this cycle (combinational from req)
//  pN_addr_i      in   ADDR_WIDTH  byte address
//  pN_we_i        in   1           1=write, 0=read
//  pN_be_i        in   BE_WIDTH    byte enables (writes only)
//  pN_wdata_i     in   DATA_WIDTH  write data
//  pN_rvalid_o    out  1           response valid, exactly 1 cycle after pN_gnt_o
//  pN_rdata_o     out  DATA_WIDTH  read data, valid while pN_rvalid_o=1 for reads
//  ram_en_o       out  1           RAM enable
//  ram_addr_o     out  ADDR_WIDTH  RAM address
//  ram_we_o       out  1           RAM write enable
//  ram_be_o       out  BE_WIDTH    RAM byte enables
//  ram_wdata_o    out  DATA_WIDTH  RAM write data
//  ram_rdata_i    in   DATA_WIDTH  RAM read data, 1 cycle after ram_en_o
// BEHAVIOUR
//  Reset (rstn_i=0, async): pN_gnt_o=0, pN_rvalid_o=0, pN_rdata_o=0, ram_en_o=0,
//   ram_we_o=0, ram_be_o=0, ram_addr_o=0, ram_wdata_o=0, last_grant=1 (port0 wins first).
//  Arbitration, same cycle as req, no wait states:
//   - Only one pN_req_i=1 -> that port granted.
//   - Both req=1 -> grant port != last_grant; the loser keeps req high, granted next cycle.
//   - No req -> no grant; ram_en_o=0, last_grant unchanged.
//   - last_grant updates on every grant edge.
//  At most one pN_gnt_o high per cycle. ram_en_o = p0_gnt_o | p1_gnt_o.
//  RAM outputs mux the granted port's addr/we/be/wdata. ram_we_o=0 when ram_en_o=0.
//  Response registers: resp_port and resp_valid captured on each grant edge.
//   - pN_rvalid_o=1 in the cycle after pN_gnt_o, for reads AND writes.
//   - Back-to-back grants give back-to-back rvalids, with no bubbles.
//  Read data:
//   - In the rvalid cycle of a read, pN_rdata_o = ram_rdata_i (pass-through).
//   - A per-port hold register captures it on that edge.
//   - Outside its rvalid cycle, pN_rdata_o = hold register.
//   - Write responses do not update the hold register.
//  Masters must keep addr/we/be/wdata stable while req=1 and gnt=0; no timeout.
//  Read after write to the same address in consecutive cycles returns the new data.
//   This is RAM behaviour; the arbiter adds no forwarding.
//  Reset asserted mid-transaction: pending rvalid is dropped and never delivered.
//   Hold registers clear to 0.
//  Throughput: 1 access/cycle total; each port gets >= 1 of every 2 cycles under contention.
// TESTING
//  T1 reset: assert rstn_i mid-burst with p0 read granted
//     -> next cycle p0_rvalid_o=0, all outputs 0; first grant after reset goes to p0.
//  T2 single port: p0 writes 0xDEADBEEF be=4'hF @0x100, then reads @0x100
//     -> two gnts back-to-back, rvalid each following cycle, read rdata=0xDEADBEEF.
//  T3 contention: p0 and p1 both hold read req for 6 cycles
//     -> grants alternate p0,p1,p0,p1,p0,p1; each rvalid routed to correct port only.
//  T4 byte enables: p1 writes 0x11223344 be=4'b0101 over 0xFFFFFFFF @0x8, reads back
//     -> rdata=0xFF22FF44.
//  T5 hold: p0 reads 0xCAFEF00D; then 5 idle cycles and p1 traffic
//     -> p0_rdata_o stays 0xCAFEF00D, p0_rvalid_o=0.
//  T6 idle: no req for 10 cycles
//     -> ram_en_o=0 throughout, no rvalid; the next contending pair grants per saved last_grant.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sp_ram_arbiter
//   Two-master round-robin arbiter in front of a single-port RAM wrapper.
//   Port0 is the core data side and port1 is the AXI/debug bridge side.
//   Each cycle at most one request is granted, combinationally from req, and
//   forwarded to the RAM. The RAM answers one cycle later. The arbiter returns
//   a response (rvalid) to the granted master in the next cycle, and routes the
//   read data through. Each port holds its last read data between responses.
//
// Ports
//   clk, rstn_i          clock (rising edge), asynchronous active-low reset
//   pN_req_i             request valid (N = 0, 1)
//   pN_gnt_o             request accepted this cycle
//   pN_addr_i/we_i/be_i/wdata_i   request payload, stable while req & !gnt
//   pN_rvalid_o          response valid, one cycle after pN_gnt_o
//   pN_rdata_o           read data (pass-through in rvalid cycle, else held)
//   ram_en_o/addr_o/we_o/be_o/wdata_o   muxed RAM access
//   ram_rdata_i          RAM read data, one cycle after ram_en_o
// -----------------------------------------------------------------------------
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn_i,

  input  logic                  p0_req_i,
  output logic                  p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic                  p0_we_i,
  input  logic [BE_WIDTH-1:0]   p0_be_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,

  input  logic                  p1_req_i,
  output logic                  p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic                  p1_we_i,
  input  logic [BE_WIDTH-1:0]   p1_be_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e                 last_grant;
  port_e                 grant_port;
  logic                  grant_any;

  port_e                 resp_port;
  logic                  resp_valid;
  logic                  resp_we;

  logic [DATA_WIDTH-1:0] p0_hold;
  logic [DATA_WIDTH-1:0] p1_hold;

  // Grant selection. Grants are gated by reset so that every output reads
  // zero while rstn_i is low, even if masters keep req asserted.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = PORT0;
    if (rstn_i) begin
      unique case ({p1_req_i, p0_req_i})
        2'b01: begin
          grant_any  = 1'b1;
          grant_port = PORT0;
        end
        2'b10: begin
          grant_any  = 1'b1;
          grant_port = PORT1;
        end
        2'b11: begin
          grant_any  = 1'b1;
          grant_port = (last_grant == PORT0) ? PORT1 : PORT0;
        end
        default: begin
          grant_any  = 1'b0;
          grant_port = PORT0;
        end
      endcase
    end
  end

  assign p0_gnt_o = grant_any && (grant_port == PORT0);
  assign p1_gnt_o = grant_any && (grant_port == PORT1);
  assign ram_en_o = grant_any;

  // RAM request mux; all fields idle at zero when nothing is granted.
  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (p0_gnt_o) begin
      ram_addr_o  = p0_addr_i;
      ram_we_o    = p0_we_i;
      ram_be_o    = p0_be_i;
      ram_wdata_o = p0_wdata_i;
    end else if (p1_gnt_o) begin
      ram_addr_o  = p1_addr_i;
      ram_we_o    = p1_we_i;
      ram_be_o    = p1_be_i;
      ram_wdata_o = p1_wdata_i;
    end
  end

  // Response tracking and per-port read-data hold registers. A hold register
  // samples ram_rdata_i on the closing edge of its own read response, so the
  // value seen in the rvalid cycle remains visible afterwards.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant <= PORT1;
      resp_valid <= 1'b0;
      resp_port  <= PORT0;
      resp_we    <= 1'b0;
      p0_hold    <= '0;
      p1_hold    <= '0;
    end else begin
      resp_valid <= grant_any;
      if (grant_any) begin
        last_grant <= grant_port;
        resp_port  <= grant_port;
        resp_we    <= ram_we_o;
      end
      if (resp_valid && !resp_we) begin
        if (resp_port == PORT0) begin
          p0_hold <= ram_rdata_i;
        end else begin
          p1_hold <= ram_rdata_i;
        end
      end
    end
  end

  assign p0_rvalid_o = resp_valid && (resp_port == PORT0);
  assign p1_rvalid_o = resp_valid && (resp_port == PORT1);

  assign p0_rdata_o = (p0_rvalid_o && !resp_we) ? ram_rdata_i : p0_hold;
  assign p1_rdata_o = (p1_rvalid_o && !resp_we) ? ram_rdata_i : p1_hold;

  // At most one grant per cycle.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rstn_i)
    !(p0_gnt_o && p1_gnt_o));

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn_i;

  logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [BW-1:0] p0_be_i, p1_be_i;
  logic [DW-1:0] p0_wdata_i, p1_wdata_i;
  logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
  logic [DW-1:0] p0_rdata_o, p1_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i = '0;

  always #5 clk = ~clk;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i),
    .p0_we_i(p0_we_i), .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i),
    .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i),
    .p1_we_i(p1_we_i), .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i),
    .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Environment RAM: 1-cycle read latency, byte-enabled writes.
  logic [DW-1:0] ram_mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int unsigned b = 0; b < BW; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o[9:2]];
      end
    end
  end

  // Transaction-level reference model.
  logic [DW-1:0] m_mem [256] = '{default: '0};
  logic [DW-1:0] m_hold [2];
  int            m_last;
  logic          m_pend, m_pwe;
  int            m_pport;
  logic [DW-1:0] m_pdata;

  int checks = 0;
  int errors = 0;

  // Values sampled at the last negedge, for literal checks.
  logic          s_gnt0, s_gnt1, s_rv0, s_rv1, s_en;
  logic [DW-1:0] s_rd0, s_rd1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance model, return at posedge+1.
  task automatic step();
    logic          req [2];
    logic          we [2];
    logic [AW-1:0] addr [2];
    logic [BW-1:0] be [2];
    logic [DW-1:0] wd [2];
    logic          rv [2];
    logic [DW-1:0] rd [2];
    logic          any;
    int            g;
    @(negedge clk);
    s_gnt0 = p0_gnt_o; s_gnt1 = p1_gnt_o; s_rv0 = p0_rvalid_o; s_rv1 = p1_rvalid_o;
    s_rd0 = p0_rdata_o; s_rd1 = p1_rdata_o; s_en = ram_en_o;
    req  = '{p0_req_i, p1_req_i};     we = '{p0_we_i, p1_we_i};
    addr = '{p0_addr_i, p1_addr_i};   be = '{p0_be_i, p1_be_i};
    wd   = '{p0_wdata_i, p1_wdata_i};
    rv   = '{p0_rvalid_o, p1_rvalid_o}; rd = '{p0_rdata_o, p1_rdata_o};
    if (!rstn_i) begin
      chk("rst_gnt0", {31'b0, p0_gnt_o}, 0);   chk("rst_gnt1", {31'b0, p1_gnt_o}, 0);
      chk("rst_en", {31'b0, ram_en_o}, 0);     chk("rst_we", {31'b0, ram_we_o}, 0);
      chk("rst_addr", {17'b0, ram_addr_o}, 0); chk("rst_be", {28'b0, ram_be_o}, 0);
      chk("rst_wdata", ram_wdata_o, 0);
      chk("rst_rvalid0", {31'b0, p0_rvalid_o}, 0); chk("rst_rvalid1", {31'b0, p1_rvalid_o}, 0);
      chk("rst_rdata0", p0_rdata_o, 0);        chk("rst_rdata1", p1_rdata_o, 0);
      m_last = 1; m_pend = 1'b0; m_hold = '{'0, '0};
    end else begin
      for (int n = 0; n < 2; n++) begin
        logic          erv;
        logic [DW-1:0] erd;
        erv = m_pend && (m_pport == n);
        erd = (erv && !m_pwe) ? m_pdata : m_hold[n];
        chk($sformatf("rvalid%0d", n), {31'b0, rv[n]}, {31'b0, erv});
        chk($sformatf("rdata%0d", n), rd[n], erd);
        if (erv && !m_pwe) m_hold[n] = m_pdata;
      end
      any = req[0] || req[1];
      if (req[0] && req[1]) g = 1 - m_last;
      else                  g = req[1] ? 1 : 0;
      chk("gnt0", {31'b0, p0_gnt_o}, {31'b0, any && g == 0});
      chk("gnt1", {31'b0, p1_gnt_o}, {31'b0, any && g == 1});
      chk("ram_en", {31'b0, ram_en_o}, {31'b0, any});
      chk("ram_we", {31'b0, ram_we_o}, {31'b0, any && we[g]});
      if (any) begin
        chk("ram_addr", {17'b0, ram_addr_o}, {17'b0, addr[g]});
        chk("ram_be", {28'b0, ram_be_o}, {28'b0, be[g]});
        chk("ram_wdata", ram_wdata_o, wd[g]);
        if (we[g]) begin
          for (int b = 0; b < BW; b++)
            if (be[g][b]) m_mem[addr[g][9:2]][8*b +: 8] = wd[g][8*b +: 8];
        end else begin
          m_pdata = m_mem[addr[g][9:2]];
        end
        m_last = g; m_pport = g; m_pwe = we[g];
      end
      m_pend = any;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic req, input logic we, input logic [AW-1:0] a,
                     input logic [BW-1:0] be, input logic [DW-1:0] wd);
    if (p == 0) begin
      p0_req_i = req; p0_we_i = we; p0_addr_i = a; p0_be_i = be; p0_wdata_i = wd;
    end else begin
      p1_req_i = req; p1_we_i = we; p1_addr_i = a; p1_be_i = be; p1_wdata_i = wd;
    end
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, '0, '0, '0);
    drv(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    idle();
    rstn_i = 1'b0;
    m_last = 1; m_pend = 1'b0; m_pwe = 1'b0; m_pport = 0; m_pdata = '0;
    m_hold = '{'0, '0};
    step(); step();
    rstn_i = 1'b1;
    step();

    // T2: p0 write then read back at 0x100.
    drv(0, 1'b1, 1'b1, 15'h100, 4'hF, 32'hDEADBEEF); step();
    chk("t2_wr_gnt", {31'b0, s_gnt0}, 1);
    drv(0, 1'b1, 1'b0, 15'h100, 4'h0, '0);          step();
    chk("t2_wr_rvalid", {31'b0, s_rv0}, 1);
    chk("t2_rd_gnt", {31'b0, s_gnt0}, 1);
    idle();                                          step();
    chk("t2_rd_rvalid", {31'b0, s_rv0}, 1);
    chk("t2_rdata", s_rd0, 32'hDEADBEEF);
    step();
    chk("t2_rvalid_off", {31'b0, s_rv0}, 0);
    chk("t2_hold", s_rd0, 32'hDEADBEEF);

    // T4: p1 partial byte-enable write over all-ones.
    drv(1, 1'b1, 1'b1, 15'h8, 4'hF, 32'hFFFFFFFF);   step();
    drv(1, 1'b1, 1'b1, 15'h8, 4'b0101, 32'h11223344); step();
    drv(1, 1'b1, 1'b0, 15'h8, 4'h0, '0);             step();
    idle();                                          step();
    chk("t4_rvalid", {31'b0, s_rv1}, 1);
    chk("t4_rdata", s_rd1, 32'hFF22FF44);

    // T5: p0 read data held across idle cycles and p1 traffic.
    drv(0, 1'b1, 1'b1, 15'h20, 4'hF, 32'hCAFEF00D);  step();
    drv(0, 1'b1, 1'b0, 15'h20, 4'h0, '0);            step();
    idle();                                          step();
    chk("t5_rdata", s_rd0, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_idle_rvalid", {31'b0, s_rv0}, 0);
      chk("t5_idle_hold", s_rd0, 32'hCAFEF00D);
    end
    drv(1, 1'b1, 1'b1, 15'h24, 4'hF, 32'h12345678);  step();
    drv(1, 1'b1, 1'b0, 15'h24, 4'h0, '0);            step();
    idle();                                          step();
    chk("t5_p1_rdata", s_rd1, 32'h12345678);
    chk("t5_p0_rvalid", {31'b0, s_rv0}, 0);
    chk("t5_p0_hold", s_rd0, 32'hCAFEF00D);

    // T6: idle, then contention resolves against last grant (p1) -> p0 first.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_en", {31'b0, s_en}, 0);
      chk("t6_rvalid", {31'b0, s_rv0 | s_rv1}, 0);
    end
    drv(0, 1'b1, 1'b0, 15'h100, 4'h0, '0);
    drv(1, 1'b1, 1'b0, 15'h8, 4'h0, '0);             step();
    chk("t6_first_gnt0", {31'b0, s_gnt0}, 1);
    drv(0, 1'b0, 1'b0, '0, '0, '0);                  step();
    chk("t6_second_gnt1", {31'b0, s_gnt1}, 1);
    chk("t6_p0_rdata", s_rd0, 32'hDEADBEEF);
    idle();                                          step();
    chk("t6_p1_rdata", s_rd1, 32'hFF22FF44);
    step();

    // T1: reset mid-transaction drops the pending p0 response.
    drv(0, 1'b1, 1'b0, 15'h8, 4'h0, '0);             step();
    chk("t1_gnt", {31'b0, s_gnt0}, 1);
    rstn_i = 1'b0;                                   step();
    chk("t1_rvalid", {31'b0, s_rv0}, 0);
    chk("t1_rdata", s_rd0, 32'h0);
    chk("t1_en", {31'b0, s_en}, 0);
    step();
    idle();
    rstn_i = 1'b1;                                   step();

    // T3: sustained contention right after reset alternates starting at p0.
    drv(0, 1'b1, 1'b0, 15'h100, 4'h0, '0);
    drv(1, 1'b1, 1'b0, 15'h20, 4'h0, '0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t3_gnt0", {31'b0, s_gnt0}, {31'b0, (k % 2) == 0});
      chk("t3_gnt1", {31'b0, s_gnt1}, {31'b0, (k % 2) == 1});
      if (k > 0) begin
        chk("t3_rv0", {31'b0, s_rv0}, {31'b0, (k % 2) == 1});
        chk("t3_rv1", {31'b0, s_rv1}, {31'b0, (k % 2) == 0});
      end
    end
    idle(); step();
    chk("t3_last_rv1", {31'b0, s_rv1}, 1);
    chk("t3_p1_rdata", s_rd1, 32'hCAFEF00D);
    chk("t3_p0_hold", s_rd0, 32'hDEADBEEF);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
